// File: rtl/ticktocktokens.sv
// ticktocktokens: array of eight token-counting event processors.
// Each processor collects tokens from its own ui_in pin and from the
// registered outputs of the processors its mask selects. When the
// count reaches the threshold, the processor fires: its output stays
// high for max(dur,1) ticks, and it ignores inputs for that time.
//
// Optional feature macro: LEAK_EN. When defined, an idle processor
// loses one count on every tick that brings it no tokens.
//
// Ports:
//   clk      tile clock
//   rst      synchronous active-high reset; clears state and configuration
//   ena      global enable; when low, nothing changes
//   ui_in    run mode: one external token per processor; program mode: write data
//   uio_in   control: [7] prog, [4:3] field select, [2:0] processor index
//   uo_out   registered active flag of each processor
//   uio_out  constant zero
//   uio_oe   constant zero (all bidirectional pins are inputs)
module ticktocktokens (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int unsigned NUM_PROC = 8;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned SUM_W    = CNT_W + 1;
   localparam int unsigned IDX_W    = 3;

   localparam logic [1:0] FLD_THR  = 2'b00;
   localparam logic [1:0] FLD_DUR  = 2'b01;
   localparam logic [1:0] FLD_MASK = 2'b10;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]    thr      [NUM_PROC];
   logic [CNT_W-1:0]    dur      [NUM_PROC];
   logic [NUM_PROC-1:0] mask     [NUM_PROC];
   logic [CNT_W-1:0]    acc      [NUM_PROC];
   logic [CNT_W-1:0]    timer    [NUM_PROC];

   logic [CNT_W-1:0]    in_cnt   [NUM_PROC];
   logic [SUM_W-1:0]    sum_raw  [NUM_PROC];
   logic [CNT_W-1:0]    sum_sat  [NUM_PROC];
   logic [CNT_W-1:0]    acc_next [NUM_PROC];
   logic [NUM_PROC-1:0] fire     ;

   logic             prog;
   logic [1:0]       field;
   logic [IDX_W-1:0] idx;
   logic             unused_ctrl;

   assign prog        = uio_in[7];
   assign field       = uio_in[4:3];
   assign idx         = uio_in[IDX_W-1:0];
   assign unused_ctrl = ^uio_in[6:5];

   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

   // Token count per processor: own pin plus masked, one-tick-old outputs.
   always_comb begin
      for (int i = 0; i < NUM_PROC; i++) begin
         in_cnt[i] = CNT_W'(ui_in[i]);
         for (int j = 0; j < NUM_PROC; j++) begin
            if (mask[i][j] && uo_out[j]) begin
               in_cnt[i] = in_cnt[i] + CNT_W'(1);
            end
         end
         sum_raw[i] = SUM_W'(acc[i]) + SUM_W'(in_cnt[i]);
         sum_sat[i] = (sum_raw[i] > SUM_W'(CNT_MAX)) ? CNT_MAX : sum_raw[i][CNT_W-1:0];
         fire[i]    = (thr[i] != '0) && (sum_sat[i] >= thr[i]);
`ifdef LEAK_EN
         if (in_cnt[i] == '0 && acc[i] != '0) begin
            acc_next[i] = acc[i] - CNT_W'(1);
         end else begin
            acc_next[i] = sum_sat[i];
         end
`else
         acc_next[i] = sum_sat[i];
`endif
      end
   end

   // Configuration writes and per-processor tick update.
   always_ff @(posedge clk) begin
      if (rst) begin
         uo_out <= '0;
         for (int i = 0; i < NUM_PROC; i++) begin
            thr[i]   <= '0;
            dur[i]   <= '0;
            mask[i]  <= '0;
            acc[i]   <= '0;
            timer[i] <= '0;
         end
      end else if (ena) begin
         if (prog) begin
            case (field)
               FLD_THR:  thr[idx]  <= ui_in[CNT_W-1:0];
               FLD_DUR:  dur[idx]  <= ui_in[CNT_W-1:0];
               FLD_MASK: mask[idx] <= ui_in;
               default:  ;
            endcase
         end else begin
            for (int i = 0; i < NUM_PROC; i++) begin
               if (uo_out[i]) begin
                  // Refractory: inputs dropped while the pulse runs.
                  if (timer[i] == CNT_W'(1)) begin
                     uo_out[i] <= 1'b0;
                     timer[i]  <= '0;
                  end else begin
                     timer[i]  <= timer[i] - CNT_W'(1);
                  end
               end else if (fire[i]) begin
                  uo_out[i] <= 1'b1;
                  timer[i]  <= (dur[i] == '0) ? CNT_W'(1) : dur[i];
                  acc[i]    <= '0;
               end else begin
                  acc[i]    <= acc_next[i];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ticktocktokens.sv
module tb_ticktocktokens;

   logic       clk;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks = 0;
   int errors = 0;

   ticktocktokens dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic prog_wr(input logic [2:0] idx, input logic [1:0] fld, input logic [7:0] data);
      uio_in = {1'b1, 2'b00, fld, idx};
      ui_in  = data;
      step();
   endtask

   task automatic tick(input logic [7:0] tokens);
      uio_in = 8'h00;
      ui_in  = tokens;
      step();
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst    = 1'b1;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      step();
      rst = 1'b0;
      chk("rst_uo", uo_out, 8'h00);
      chk("rst_uio_out", uio_out, 8'h00);
      chk("rst_uio_oe", uio_oe, 8'h00);

      // thr=0 disables every processor
      tick(8'hFF); chk("dis_t1", uo_out, 8'h00);
      tick(8'hFF); chk("dis_t2", uo_out, 8'h00);
      tick(8'hFF); chk("dis_t3", uo_out, 8'h00);

      // reset clears the accumulated counts
      rst = 1'b1; step(); rst = 1'b0;
      chk("rst2_uo", uo_out, 8'h00);

      // proc0 thr=3 dur=2
      prog_wr(3'd0, 2'b00, 8'h03);
      prog_wr(3'd0, 2'b01, 8'h02);
      chk("prog_no_tick", uo_out, 8'h00);
      tick(8'h01); chk("p0_acc1", uo_out, 8'h00);
      tick(8'h01); chk("p0_acc2", uo_out, 8'h00);
      tick(8'h01); chk("p0_fire", uo_out, 8'h01);
      tick(8'h01); chk("p0_refr", uo_out, 8'h01);
      tick(8'h01); chk("p0_off", uo_out, 8'h00);
      tick(8'h00); chk("p0_idle", uo_out, 8'h00);

      // chain: proc0 -> proc1
      prog_wr(3'd0, 2'b00, 8'h01);
      prog_wr(3'd0, 2'b01, 8'h01);
      prog_wr(3'd1, 2'b00, 8'h01);
      prog_wr(3'd1, 2'b01, 8'h03);
      prog_wr(3'd1, 2'b10, 8'h01);
      tick(8'h01); chk("ch_p0", uo_out, 8'h01);
      tick(8'h00); chk("ch_p1a", uo_out, 8'h02);
      tick(8'h00); chk("ch_p1b", uo_out, 8'h02);
      tick(8'h00); chk("ch_p1c", uo_out, 8'h02);
      tick(8'h00); chk("ch_off", uo_out, 8'h00);

      // saturation with dur=0: proc2 counts 1,4,5,8,9,12,13, then 16 -> 15
      prog_wr(3'd1, 2'b10, 8'h00);
      prog_wr(3'd1, 2'b01, 8'h01);
      prog_wr(3'd2, 2'b00, 8'h0F);
      prog_wr(3'd2, 2'b01, 8'h00);
      prog_wr(3'd2, 2'b10, 8'hFF);
      tick(8'h07); chk("sat_t1", uo_out, 8'h03);
      tick(8'h07); chk("sat_t2", uo_out, 8'h00);
      tick(8'h07); chk("sat_t3", uo_out, 8'h03);
      tick(8'h07); chk("sat_t4", uo_out, 8'h00);
      tick(8'h07); chk("sat_t5", uo_out, 8'h03);
      tick(8'h07); chk("sat_t6", uo_out, 8'h00);
      tick(8'h07); chk("sat_t7", uo_out, 8'h03);
      tick(8'h07); chk("sat_fire", uo_out, 8'h04);
      tick(8'h07); chk("sat_1cyc", uo_out, 8'h03);
      tick(8'h00); chk("sat_stop", uo_out, 8'h00);
      prog_wr(3'd2, 2'b00, 8'h00);

      // ena=0 freezes a running pulse with 2 ticks left
      prog_wr(3'd0, 2'b01, 8'h03);
      tick(8'h01); chk("ena_fire", uo_out, 8'h01);
      tick(8'h00); chk("ena_t2", uo_out, 8'h01);
      ena = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick(8'hFF);
         chk("ena_hold", uo_out, 8'h01);
      end
      prog_wr(3'd1, 2'b00, 8'h0F);
      chk("ena_hold_prog", uo_out, 8'h01);
      ena = 1'b1;
      tick(8'h00); chk("ena_last", uo_out, 8'h01);
      tick(8'h00); chk("ena_off", uo_out, 8'h00);
      // proc1 thr write under ena=0 must have been ignored: thr still 1
      tick(8'h02); chk("ena_noprog", uo_out, 8'h02);
      tick(8'h00); chk("ena_p1off", uo_out, 8'h00);

      // leak: thr=3, inputs on 2 ticks, 2 idle ticks, 1 input
      prog_wr(3'd0, 2'b00, 8'h03);
      prog_wr(3'd0, 2'b01, 8'h01);
      tick(8'h01); chk("lk_in1", uo_out, 8'h00);
      tick(8'h01); chk("lk_in2", uo_out, 8'h00);
      tick(8'h00); chk("lk_idle1", uo_out, 8'h00);
      tick(8'h00); chk("lk_idle2", uo_out, 8'h00);
      tick(8'h01);
`ifdef LEAK_EN
      chk("lk_in3", uo_out, 8'h00);
`else
      chk("lk_in3", uo_out, 8'h01);
`endif
      tick(8'h00); chk("lk_after", uo_out, 8'h00);

      // reset mid-operation clears configuration as well
      tick(8'h01);
      rst = 1'b1; step(); rst = 1'b0;
      chk("rst3_uo", uo_out, 8'h00);
      tick(8'hFF); chk("rst3_cfg", uo_out, 8'h00);
      tick(8'hFF); chk("rst3_cfg2", uo_out, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ticktocktokens.md
# ticktocktokens

Token-counting event processor array for the TinyTapeout tile `tt_um_jleugeri_ticktocktokens`. Eight processors each accumulate input tokens from dedicated pins and from other processors' outputs. When a processor's count reaches its programmed threshold, it fires: its output goes high for a programmed number of ticks. Configuration (thresholds, durations, connection masks) is written through the bidirectional pins.

## Interface
- NUM_PROC, 8, number of processors (fixed by pin count)
- CNT_W, 4, width of accumulator, threshold, duration and timer
- clk  in  1  tile clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- ena  in  1  global enable; when 0, no state changes (no ticks, no writes)
- ui_in  in  8  run mode: external token per processor (bit i → proc i); program mode: write data
- uio_in  in  8  control: [7] prog, [4:3] field select, [2:0] processor index
- uo_out  out  8  bit i = proc i active (registered)
- uio_out  out  8  constant 8'h00
- uio_oe  out  8  constant 8'h00 (all bidirectional pins are inputs)

## Operation
- Per-processor state:
  - thr[3:0]
  - dur[3:0]
  - mask[7:0] (bit j: listen to proc j; self allowed)
  - acc[3:0]
  - timer[3:0]
  - active
- Reset: all state cleared to 0; uo_out = 0. With thr = 0 a processor is disabled, so all processors are idle after reset.
- Program cycle (ena=1, uio_in[7]=1): write to proc uio_in[2:0]; no tick occurs.
  - field 00: thr ← ui_in[3:0]
  - field 01: dur ← ui_in[3:0]
  - field 10: mask ← ui_in[7:0]
  - field 11: no-op
- Tick (ena=1, uio_in[7]=0), for each proc i in parallel, using pre-edge values:
  - in_i = ui_in[i] + popcount(mask_i & active_vector). active_vector is the registered uo_out, so feedback has one tick of delay. Range is 0..9.
  - If active:
    - inputs are discarded (refractory);
    - if timer == 1: active ← 0, timer ← 0; else timer ← timer−1.
  - If not active:
    - sum = acc + in_i, saturating at 15.
    - If thr ≠ 0 and sum ≥ thr: fire. active ← 1, timer ← max(dur,1), acc ← 0.
    - Otherwise acc ← sum.
- Rewriting thr/dur/mask of an active processor does not alter its running timer; new values apply to later comparisons and fires.
- A program write and a tick never coincide (uio_in[7] selects exactly one).

## Timing
- All outputs registered; no combinational path from inputs to uo_out.
- Fire latency: if the threshold is crossed by inputs sampled at edge N, uo_out[i] is high from edge N until edge N+max(dur,1).
  - Output is high for exactly max(dur,1) ticks.
  - The processor may accumulate again starting with the tick after it deactivates.
- Feedback: proc j firing at edge N contributes to proc i's count at edge N+1.
- ena=0 cycles are invisible: timers, accumulators and configuration are all held.
- Reset mid-operation: all state and outputs are zero after the reset edge, including configuration.

## Configuration
- LEAK_EN defined: on a tick where a non-active processor gets in_i = 0 and acc > 0, acc ← acc−1. Leak never underflows below 0. Leak never applies in the same tick as an input.
- LEAK_EN undefined: acc holds its value indefinitely between inputs.

## Test plan
- Reset → uo_out=0x00, uio_out=0x00, uio_oe=0x00. Ticks with ui_in=0xFF afterward → uo_out stays 0x00, because thr=0 disables all processors.
- Proc 0: thr=3, dur=2. Pulse ui_in[0] on 3 ticks → uo_out[0] rises after the 3rd tick edge and is high for exactly 2 cycles. A further input during those cycles does not extend or retrigger.
- Chain: proc0 thr=1 dur=1; proc1 thr=1 dur=3, mask=0x01. One ui_in[0] tick → uo_out[0] high 1 cycle, then uo_out[1] high 3 cycles starting one cycle later.
- Saturation and duration 0: proc2 thr=15, dur=0, mask=0xFF, with proc0/1 held firing. Accumulation saturates to 15 and fires → uo_out[2] high exactly 1 cycle.
- ena=0 held for 5 cycles mid-activity (uo_out[0] high with 2 ticks left) → uo_out unchanged. After ena returns, exactly 2 more ticks high.
- LEAK_EN: thr=3; input on 2 ticks, then 2 idle ticks, then 1 input → no fire with leak (acc 2→0→1); fires without LEAK_EN.
